// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ toggle-handshake requesters onto a single uart_send port.
// Round-robin selection with optional per-requester lock across consecutive words.
module uart_tx_arb #(
  parameter int DATABITS = 8,
  parameter int NREQ     = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ*DATABITS-1:0] req_data,
  input  logic [NREQ-1:0]          req_seq,
  output logic [NREQ-1:0]          req_ack,
  input  logic [NREQ-1:0]          req_lock,
  output logic [DATABITS-1:0]      tx_data,
  output logic                     tx_seq,
  input  logic                     tx_ack,
  output logic [$clog2(NREQ)-1:0]  grant,
  output logic                     busy
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [1:0] {StDrain, StIdle, StSend} state_e;

  state_e              r_state, w_state_nxt;
  logic [DATABITS-1:0] r_tx_data, w_tx_data_nxt;
  logic                r_tx_seq, w_tx_seq_nxt;
  logic [NREQ-1:0]     r_req_ack, w_req_ack_nxt;
  logic [GW-1:0]       r_grant, w_grant_nxt;
  logic                r_owner, w_owner_nxt;
  logic                r_seq_cap, w_seq_cap_nxt;

  logic [NREQ-1:0]     w_pend;
  logic                w_locked;
  logic                w_found;
  logic [GW-1:0]       w_sel;
  logic [GW-1:0]       w_idx;

  assign w_pend   = req_seq ^ r_req_ack;
  assign w_locked = r_owner && req_lock[r_grant];

  // Round-robin scan starting one past the last grant; a live lock overrides it.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_grant;
    w_idx   = r_grant;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = GW'((int'(r_grant) + k) % NREQ);
      if (!w_found && w_pend[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    if (w_locked) begin
      w_found = w_pend[r_grant];
      w_sel   = r_grant;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_data_nxt = r_tx_data;
    w_tx_seq_nxt  = r_tx_seq;
    w_req_ack_nxt = r_req_ack;
    w_grant_nxt   = r_grant;
    w_seq_cap_nxt = r_seq_cap;
    w_owner_nxt   = r_owner & req_lock[r_grant];
    unique case (r_state)
      // uart_send keeps its ack across our reset, so wait for it to match tx_seq.
      StDrain: begin
        if (tx_ack == r_tx_seq) w_state_nxt = StIdle;
      end
      StIdle: begin
        if (w_found) begin
          w_tx_data_nxt = req_data[w_sel*DATABITS +: DATABITS];
          w_tx_seq_nxt  = ~r_tx_seq;
          w_grant_nxt   = w_sel;
          w_seq_cap_nxt = req_seq[w_sel];
          w_owner_nxt   = req_lock[w_sel];
          w_state_nxt   = StSend;
        end
      end
      StSend: begin
        if (tx_ack == r_tx_seq) begin
          w_req_ack_nxt[r_grant] = r_seq_cap;
          w_state_nxt            = StIdle;
        end
      end
      default: w_state_nxt = StDrain;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StDrain;
      r_tx_data <= '0;
      r_tx_seq  <= 1'b0;
      r_req_ack <= '0;
      r_grant   <= GW'(NREQ - 1);
      r_owner   <= 1'b0;
      r_seq_cap <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_tx_seq  <= w_tx_seq_nxt;
      r_req_ack <= w_req_ack_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_seq_cap <= w_seq_cap_nxt;
    end
  end

  assign tx_data = r_tx_data;
  assign tx_seq  = r_tx_seq;
  assign req_ack = r_req_ack;
  assign grant   = r_grant;
  assign busy    = (r_state != StIdle);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: single-word table plus round-robin, lock,
// data-hold, reset-abandon and drain sequences.
module tb_uart_tx_arb;

  logic        clk;
  logic        reset;
  logic [31:0] req_data;
  logic [3:0]  req_seq;
  logic [3:0]  req_ack;
  logic [3:0]  req_lock;
  logic [7:0]  tx_data;
  logic        tx_seq;
  logic        tx_ack;
  logic [1:0]  grant;
  logic        busy;

  uart_tx_arb #(
    .DATABITS(8),
    .NREQ    (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req_data(req_data),
    .req_seq (req_seq),
    .req_ack (req_ack),
    .req_lock(req_lock),
    .tx_data (tx_data),
    .tx_seq  (tx_seq),
    .tx_ack  (tx_ack),
    .grant   (grant),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [1:0] exp_grant;
    logic [7:0] exp_data;
    logic       exp_seq;
  } vec_t;

  vec_t       vecs [4];
  int         n_checks = 0;
  int         n_errors = 0;
  logic       m_seq;
  logic [3:0] m_ack;
  logic [7:0] exp_d;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  initial begin
    vecs[0] = '{2, 8'hA5, 2'd2, 8'hA5, 1'b0};
    vecs[1] = '{1, 8'h3C, 2'd1, 8'h3C, 1'b1};
    vecs[2] = '{0, 8'h00, 2'd0, 8'h00, 1'b0};
    vecs[3] = '{3, 8'hFF, 2'd3, 8'hFF, 1'b1};

    reset    = 1'b1;
    tx_ack   = 1'b0;
    req_data = '0;
    req_seq  = '0;
    req_lock = '0;
    #12;
    chk("rst_tx_seq", tx_seq, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_grant", grant, 3);
    chk("rst_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;

    tick();
    chk("idle_after_release", busy, 0);
    req_data[7:0] = 8'h55;
    req_seq       = 4'b0001;
    tick();
    chk("first_tx_seq", tx_seq, 1);
    chk("first_tx_data", tx_data, 8'h55);
    chk("first_grant", grant, 0);
    chk("first_busy", busy, 1);
    chk("first_ack_pending", req_ack, 0);
    tx_ack = 1'b1;
    tick();
    chk("first_req_ack", req_ack, 4'b0001);
    chk("first_done_busy", busy, 0);
    m_seq = 1'b1;
    m_ack = 4'b0001;

    repeat (3) tick();
    chk("hold_tx_data", tx_data, 8'h55);
    chk("hold_tx_seq", tx_seq, m_seq);
    chk("hold_grant", grant, 0);

    for (int i = 0; i < 4; i++) begin
      req_data[vecs[i].idx*8 +: 8] = vecs[i].data;
      req_seq[vecs[i].idx]         = ~req_seq[vecs[i].idx];
      tick();
      chk($sformatf("vec%0d_grant", i), grant, vecs[i].exp_grant);
      chk($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_tx_seq", i), tx_seq, vecs[i].exp_seq);
      chk($sformatf("vec%0d_busy", i), busy, 1);
      chk($sformatf("vec%0d_ack_held", i), req_ack, m_ack);
      tx_ack = vecs[i].exp_seq;
      tick();
      m_ack[vecs[i].idx] = req_seq[vecs[i].idx];
      chk($sformatf("vec%0d_req_ack", i), req_ack, m_ack);
      chk($sformatf("vec%0d_idle", i), busy, 0);
    end
    m_seq = 1'b1;

    // All four pending together with grant=3: expect 0,1,2,3 back to back.
    req_data = 32'h44332211;
    req_seq  = ~req_seq;
    tick();
    for (int k = 0; k < 4; k++) begin
      m_seq = ~m_seq;
      exp_d = 8'((k + 1) * 17);
      chk($sformatf("rr%0d_grant", k), grant, k);
      chk($sformatf("rr%0d_tx_data", k), tx_data, exp_d);
      chk($sformatf("rr%0d_tx_seq", k), tx_seq, m_seq);
      tx_ack = m_seq;
      tick();
      m_ack[k] = req_seq[k];
      chk($sformatf("rr%0d_req_ack", k), req_ack, m_ack);
      chk($sformatf("rr%0d_no_early_toggle", k), tx_seq, m_seq);
      if (k < 3) tick();
    end
    chk("rr_end_idle", busy, 0);

    // Requester 2 locks for three words while requester 0 waits.
    req_lock         = 4'b0100;
    req_data[23:16]  = 8'hB1;
    req_seq[2]       = ~req_seq[2];
    tick();
    m_seq = ~m_seq;
    chk("lock0_grant", grant, 2);
    chk("lock0_tx_data", tx_data, 8'hB1);
    chk("lock0_tx_seq", tx_seq, m_seq);
    req_data[7:0] = 8'hC0;
    req_seq[0]    = ~req_seq[0];
    for (int w = 0; w < 3; w++) begin
      tx_ack = m_seq;
      tick();
      m_ack[2] = req_seq[2];
      chk($sformatf("lock%0d_req_ack", w), req_ack, m_ack);
      tick();
      chk($sformatf("lock%0d_wait_busy", w), busy, 0);
      chk($sformatf("lock%0d_wait_grant", w), grant, 2);
      if (w < 2) begin
        exp_d           = 8'hB2 + 8'(w);
        req_data[23:16] = exp_d;
        req_seq[2]      = ~req_seq[2];
        tick();
        m_seq = ~m_seq;
        chk($sformatf("lock%0d_next_grant", w), grant, 2);
        chk($sformatf("lock%0d_next_data", w), tx_data, exp_d);
        chk($sformatf("lock%0d_next_seq", w), tx_seq, m_seq);
      end
    end
    req_lock = 4'b0000;
    tick();
    m_seq = ~m_seq;
    chk("unlock_grant", grant, 0);
    chk("unlock_tx_data", tx_data, 8'hC0);
    chk("unlock_tx_seq", tx_seq, m_seq);
    tx_ack = m_seq;
    tick();
    m_ack[0] = req_seq[0];
    chk("unlock_req_ack", req_ack, m_ack);

    // Word in flight must not follow req_data changes.
    req_data[15:8] = 8'hA0;
    req_seq[1]     = ~req_seq[1];
    tick();
    m_seq = ~m_seq;
    chk("hold_sel_grant", grant, 1);
    chk("hold_sel_data", tx_data, 8'hA0);
    req_data[15:8] = 8'h0F;
    repeat (2) tick();
    chk("hold_send_data", tx_data, 8'hA0);
    chk("hold_send_busy", busy, 1);
    chk("hold_send_seq", tx_seq, m_seq);
    tx_ack = m_seq;
    tick();
    m_ack[1] = req_seq[1];
    chk("hold_done_data", tx_data, 8'hA0);
    chk("hold_done_ack", req_ack, m_ack);
    tick();
    chk("hold_idle_data", tx_data, 8'hA0);

    // Reset mid-SEND for requester 1, transmitter then holds ack high.
    req_data[15:8] = 8'h77;
    req_seq[1]     = ~req_seq[1];
    tick();
    chk("abort_busy", busy, 1);
    chk("abort_grant", grant, 1);
    chk("abort_data", tx_data, 8'h77);
    #2;
    reset   = 1'b1;
    req_seq = '0;
    tx_ack  = 1'b1;
    #1;
    chk("abort_rst_tx_seq", tx_seq, 0);
    chk("abort_rst_req_ack", req_ack, 0);
    chk("abort_rst_busy", busy, 1);
    chk("abort_rst_tx_data", tx_data, 0);
    chk("abort_rst_grant", grant, 3);
    @(negedge clk);
    reset         = 1'b0;
    req_data[7:0] = 8'h5A;
    req_seq       = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("drain%0d_busy", c), busy, 1);
      chk($sformatf("drain%0d_grant", c), grant, 3);
      chk($sformatf("drain%0d_tx_seq", c), tx_seq, 0);
      chk($sformatf("drain%0d_req_ack", c), req_ack, 0);
    end
    tx_ack = 1'b0;
    tick();
    chk("drain_exit_busy", busy, 0);
    chk("drain_exit_tx_seq", tx_seq, 0);
    tick();
    chk("post_drain_grant", grant, 0);
    chk("post_drain_data", tx_data, 8'h5A);
    chk("post_drain_seq", tx_seq, 1);
    tx_ack = 1'b1;
    tick();
    chk("post_drain_ack", req_ack, 4'b0001);
    chk("post_drain_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
